// File: rtl/uart_reg_sequencer.sv
// uart_reg_sequencer
// Single owner of a 16550-style UART register port. After reset it programs
// the baud divisor, line control, FIFO control and interrupt enable
// registers. It then polls the line status register and moves bytes between
// a valid/ready byte-stream interface and the UART's THR/RBR.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   uart_addr_o   UART register address (0 when no strobe is active)
//   uart_wdata_o  UART write data (0 when no write is active)
//   uart_rdata_i  UART read data, valid in the cycle after a read strobe
//   uart_we_o     single-cycle write strobe
//   uart_re_o     single-cycle read strobe
//   tx_valid      transmit byte offered
//   tx_data       transmit byte, stable while tx_valid is high
//   tx_ready      high only in the cycle the byte is written to THR
//   rx_valid      received byte held in rx_data
//   rx_data       received byte
//   rx_ready      consumer accepts rx_data when rx_valid is also high
//   init_done     high once the register init sequence has completed
module uart_reg_sequencer #(
    parameter logic [15:0] DIVISOR  = 16'd27,
    parameter logic [7:0]  LCR_VAL  = 8'h03,
    parameter logic [7:0]  FCR_VAL  = 8'h07,
    parameter int          POLL_GAP = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] uart_addr_o,
    output logic [7:0] uart_wdata_o,
    input  logic [7:0] uart_rdata_i,
    output logic       uart_we_o,
    output logic       uart_re_o,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       init_done
);

    typedef enum logic [3:0] {
        INIT0, INIT1, INIT2, INIT3, INIT4, INIT5,
        POLL, LSR_CAP, RBR_RD, RBR_CAP, THR_WR, GAP
    } state_t;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_IER  = 3'd1;
    localparam logic [2:0] ADDR_FCR  = 3'd2;
    localparam logic [2:0] ADDR_LCR  = 3'd3;
    localparam logic [2:0] ADDR_LSR  = 3'd5;

    localparam logic [7:0] LCR_DLAB = LCR_VAL | 8'h80;
    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

    state_t     state;
    state_t     next_state;
    logic       started;
    logic [7:0] gap_cnt;
    logic       rx_empty;

    // The holding register counts as free if it is empty now or is being
    // drained in this same cycle, so a consumed byte can be replaced without
    // losing a poll round.
    assign rx_empty = !rx_valid || rx_ready;

    // tx_ready is a pure decode of the current state so that the handshake
    // coincides exactly with the THR write, and it collapses with the state
    // register the moment reset is asserted.
    assign tx_ready = (state == THR_WR);

    // Next-state logic. The state register names the action being presented
    // on the UART port in the current cycle. Right after reset nothing has
    // been presented yet, so the first edge presents INIT0 rather than
    // advancing past it. In LSR_CAP the UART's read data for the LSR poll is
    // valid, so the transfer decision is taken from it directly.
    always_comb begin
        next_state = state;
        if (!started) begin
            next_state = INIT0;
        end else begin
            case (state)
                INIT0:   next_state = INIT1;
                INIT1:   next_state = INIT2;
                INIT2:   next_state = INIT3;
                INIT3:   next_state = INIT4;
                INIT4:   next_state = INIT5;
                INIT5:   next_state = POLL;
                POLL:    next_state = LSR_CAP;
                LSR_CAP: begin
                    if (uart_rdata_i[0] && rx_empty) begin
                        next_state = RBR_RD;
                    end else if (uart_rdata_i[5] && tx_valid) begin
                        next_state = THR_WR;
                    end else begin
                        next_state = GAP;
                    end
                end
                RBR_RD:  next_state = RBR_CAP;
                RBR_CAP: next_state = POLL;
                THR_WR:  next_state = POLL;
                GAP:     next_state = (gap_cnt == GAP_LAST) ? POLL : GAP;
                default: next_state = INIT0;
            endcase
        end
    end

    // Sequencer registers. Port outputs are registered from the state being
    // entered, so every strobe, address and data byte is glitch-free and
    // lines up with the state that owns it. Address and data return to zero
    // whenever no strobe is active. The RX holding register loads in RBR_CAP,
    // when the RBR read data is valid, and otherwise drains on a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= INIT0;
            started      <= 1'b0;
            gap_cnt      <= 8'd0;
            uart_addr_o  <= 3'd0;
            uart_wdata_o <= 8'd0;
            uart_we_o    <= 1'b0;
            uart_re_o    <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= 8'd0;
            init_done    <= 1'b0;
        end else begin
            started <= 1'b1;
            state   <= next_state;

            if (state == GAP && next_state == GAP) begin
                gap_cnt <= gap_cnt + 8'd1;
            end else begin
                gap_cnt <= 8'd0;
            end

            uart_we_o    <= 1'b0;
            uart_re_o    <= 1'b0;
            uart_addr_o  <= 3'd0;
            uart_wdata_o <= 8'd0;
            case (next_state)
                INIT0: begin
                    uart_we_o    <= 1'b1;
                    uart_addr_o  <= ADDR_LCR;
                    uart_wdata_o <= LCR_DLAB;
                end
                INIT1: begin
                    uart_we_o    <= 1'b1;
                    uart_addr_o  <= ADDR_DATA;
                    uart_wdata_o <= DIVISOR[7:0];
                end
                INIT2: begin
                    uart_we_o    <= 1'b1;
                    uart_addr_o  <= ADDR_IER;
                    uart_wdata_o <= DIVISOR[15:8];
                end
                INIT3: begin
                    uart_we_o    <= 1'b1;
                    uart_addr_o  <= ADDR_LCR;
                    uart_wdata_o <= LCR_VAL;
                end
                INIT4: begin
                    uart_we_o    <= 1'b1;
                    uart_addr_o  <= ADDR_FCR;
                    uart_wdata_o <= FCR_VAL;
                end
                INIT5: begin
                    uart_we_o    <= 1'b1;
                    uart_addr_o  <= ADDR_IER;
                    uart_wdata_o <= 8'h00;
                end
                POLL: begin
                    uart_re_o   <= 1'b1;
                    uart_addr_o <= ADDR_LSR;
                end
                RBR_RD: begin
                    uart_re_o   <= 1'b1;
                    uart_addr_o <= ADDR_DATA;
                end
                THR_WR: begin
                    uart_we_o    <= 1'b1;
                    uart_addr_o  <= ADDR_DATA;
                    uart_wdata_o <= tx_data;
                end
                default: begin
                end
            endcase

            if (state == INIT5) begin
                init_done <= 1'b1;
            end

            if (state == RBR_CAP) begin
                rx_data  <= uart_rdata_i;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_reg_sequencer.sv
// tb_uart_reg_sequencer
// Self-checking bench for uart_reg_sequencer. A small UART model answers
// register reads one cycle after the read strobe. Every strobe on the UART
// port is logged as a transaction; a transaction-level model predicts, for
// each LSR poll, which access follows and when, and tracks the one-entry RX
// holding register.
module tb_uart_reg_sequencer;

    localparam logic [15:0] DIVISOR  = 16'd27;
    localparam logic [7:0]  LCR_VAL  = 8'h03;
    localparam logic [7:0]  FCR_VAL  = 8'h07;
    localparam int          POLL_GAP = 8;

    typedef struct {
        int         cyc;
        logic       we;
        logic       re;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic       txr;
        logic       idone;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] uart_addr_o;
    logic [7:0] uart_wdata_o;
    logic [7:0] uart_rdata_i;
    logic       uart_we_o;
    logic       uart_re_o;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       init_done;

    logic [7:0] lsr_val;
    logic [7:0] rbr_val;

    int  cyc;
    int  checks;
    int  errors;
    int  both_hot;
    int  txr_bad;
    int  idle_bad;
    int  poll_cyc;
    bit  occ;
    logic [7:0] occ_data;
    ev_t events[$];

    uart_reg_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_addr_o  (uart_addr_o),
        .uart_wdata_o (uart_wdata_o),
        .uart_rdata_i (uart_rdata_i),
        .uart_we_o    (uart_we_o),
        .uart_re_o    (uart_re_o),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .init_done    (init_done)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter: a value logged at a falling edge names the cycle that
    // the preceding rising edge started.
    initial cyc = 0;
    always @(posedge clk) cyc++;

    // UART register file model: a read returns LSR or RBR in the cycle after
    // the read strobe, as a registered read port would.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_rdata_i <= 8'h00;
        end else if (uart_re_o) begin
            uart_rdata_i <= (uart_addr_o == 3'd5) ? lsr_val :
                            (uart_addr_o == 3'd0) ? rbr_val : 8'h00;
        end
    end

    // Transaction logger plus per-cycle port rules: never both strobes,
    // tx_ready only alongside a post-init data-register write, and address
    // and data parked at zero when the port is idle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (uart_we_o || uart_re_o) begin
                events.push_back('{cyc, uart_we_o, uart_re_o, uart_addr_o,
                                   uart_wdata_o, tx_ready, init_done});
            end
            if (uart_we_o && uart_re_o) both_hot++;
            if (tx_ready !== (uart_we_o && uart_addr_o == 3'd0 && init_done)) txr_bad++;
            if (!uart_we_o && !uart_re_o && (uart_addr_o != 3'd0 || uart_wdata_o != 8'd0)) idle_bad++;
        end
    end

    // Hard stop in case the sequence wedges somewhere unbounded.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic getEvent(input string tag, output ev_t e);
        int waited;
        waited = 0;
        while (events.size() == 0 && waited < 64) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (events.size() == 0) begin
            checkOutput({tag, "_timeout"}, events.size(), 1);
            e = '{default: '0};
        end else begin
            e = events.pop_front();
        end
    endtask

    task automatic checkPoll(input string tag, input ev_t e, input int exp_cyc);
        checkOutput({tag, "_poll_access"}, {e.we, e.re, e.addr}, {1'b0, 1'b1, 3'd5});
        checkOutput({tag, "_poll_cycle"}, e.cyc, exp_cyc);
    endtask

    // Releases reset and expects the six init writes on consecutive cycles
    // starting one cycle after release, then the first LSR poll with
    // init_done already high.
    task automatic checkInit(input string tag);
        logic [2:0] ia [6];
        logic [7:0] id [6];
        ev_t e;
        int  rel;
        ia = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
        id = '{8'h80 | LCR_VAL, DIVISOR[7:0], DIVISOR[15:8], LCR_VAL, FCR_VAL, 8'h00};
        @(negedge clk);
        events.delete();
        rst_n = 1'b1;
        rel = cyc;
        for (int k = 0; k < 6; k++) begin
            getEvent({tag, "_init"}, e);
            checkOutput({tag, "_init_write"}, {e.we, e.re, e.addr, e.wdata}, {1'b1, 1'b0, ia[k], id[k]});
            checkOutput({tag, "_init_cycle"}, e.cyc, rel + 1 + k);
            checkOutput({tag, "_init_done_low"}, e.idone, 0);
        end
        getEvent({tag, "_first_poll"}, e);
        checkPoll({tag, "_first"}, e, rel + 7);
        checkOutput({tag, "_init_done_high"}, e.idone, 1);
        poll_cyc = e.cyc;
        occ = 1'b0;
    endtask

    // Called in the cycle of an LSR poll: applies the LSR value and stream
    // inputs for this round, predicts the access that follows from the
    // poll rules, and leaves the bench sitting in the next poll cycle.
    task automatic applyStimulus(input logic [7:0] lsr, input logic txv, input logic [7:0] txd,
                                 input logic rdy, input logic [7:0] rbr);
        ev_t e;
        int  n;
        bit  empty;
        n = poll_cyc;
        lsr_val  = lsr;
        tx_valid = txv;
        tx_data  = txd;
        rx_ready = rdy;
        rbr_val  = rbr;
        empty = !occ || rdy;
        if (lsr[0] && empty) begin
            getEvent("rbr", e);
            checkOutput("rbr_access", {e.we, e.re, e.addr}, {1'b0, 1'b1, 3'd0});
            checkOutput("rbr_cycle", e.cyc, n + 2);
            getEvent("after_rbr", e);
            checkPoll("after_rbr", e, n + 4);
            occ = 1'b1;
            occ_data = rbr;
        end else if (lsr[5] && txv) begin
            getEvent("thr", e);
            checkOutput("thr_write", {e.we, e.re, e.addr, e.wdata}, {1'b1, 1'b0, 3'd0, txd});
            checkOutput("thr_tx_ready", e.txr, 1);
            checkOutput("thr_cycle", e.cyc, n + 2);
            getEvent("after_thr", e);
            checkPoll("after_thr", e, n + 3);
            if (rdy) occ = 1'b0;
        end else begin
            getEvent("gap", e);
            checkPoll("after_gap", e, n + 2 + POLL_GAP);
            if (rdy) occ = 1'b0;
        end
        poll_cyc = e.cyc;
        checkOutput("rx_valid", rx_valid, occ);
        if (occ) checkOutput("rx_data", rx_data, occ_data);
    endtask

    // Directed scenarios followed by a randomized run and a reset in the
    // middle of a THR write.
    initial begin
        ev_t e;
        logic [7:0] lsr;
        checks = 0;
        errors = 0;
        both_hot = 0;
        txr_bad = 0;
        idle_bad = 0;
        rst_n = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        rx_ready = 1'b0;
        lsr_val = 8'h60;
        rbr_val = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("reset_strobes", {uart_we_o, uart_re_o, tx_ready}, 0);
        checkOutput("reset_port", {uart_addr_o, uart_wdata_o}, 0);
        checkOutput("reset_rx", {rx_valid, rx_data}, 0);
        checkOutput("reset_init_done", init_done, 0);

        checkInit("boot");

        applyStimulus(8'h60, 1'b0, 8'h00, 1'b0, 8'h00);
        applyStimulus(8'h60, 1'b0, 8'h00, 1'b0, 8'h00);
        applyStimulus(8'h20, 1'b1, 8'hA5, 1'b0, 8'h00);
        applyStimulus(8'h20, 1'b1, 8'h5E, 1'b0, 8'h00);
        applyStimulus(8'h01, 1'b0, 8'h00, 1'b0, 8'h3C);
        applyStimulus(8'h01, 1'b0, 8'h00, 1'b0, 8'h3D);
        applyStimulus(8'h01, 1'b0, 8'h00, 1'b0, 8'h3E);
        applyStimulus(8'h01, 1'b0, 8'h00, 1'b1, 8'h5A);
        applyStimulus(8'h60, 1'b0, 8'h00, 1'b1, 8'h00);
        applyStimulus(8'h21, 1'b1, 8'h77, 1'b0, 8'h99);
        applyStimulus(8'h21, 1'b1, 8'h77, 1'b0, 8'h9A);
        applyStimulus(8'h60, 1'b0, 8'h00, 1'b1, 8'h00);

        for (int i = 0; i < 40; i++) begin
            lsr = 8'($urandom) & 8'hDE;
            lsr[0] = ($urandom_range(0, 1) == 1);
            lsr[5] = ($urandom_range(0, 3) != 0);
            applyStimulus(lsr, 1'($urandom_range(0, 1)), 8'($urandom),
                          ($urandom_range(0, 2) == 0), 8'($urandom));
        end

        lsr_val  = 8'h20;
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        rx_ready = 1'b0;
        getEvent("reset_thr", e);
        checkOutput("reset_thr_write", {e.we, e.addr, e.wdata}, {1'b1, 3'd0, 8'hC3});
        checkOutput("reset_thr_tx_ready", tx_ready, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_strobes", {uart_we_o, uart_re_o, tx_ready}, 0);
        checkOutput("midreset_port", {uart_addr_o, uart_wdata_o}, 0);
        checkOutput("midreset_rx", {rx_valid, rx_data}, 0);
        checkOutput("midreset_init_done", init_done, 0);
        repeat (2) @(negedge clk);

        checkInit("reinit");
        applyStimulus(8'h20, 1'b1, 8'hC3, 1'b0, 8'h00);
        applyStimulus(8'h60, 1'b0, 8'h00, 1'b0, 8'h00);

        checkOutput("both_strobes_cycles", both_hot, 0);
        checkOutput("tx_ready_misplaced_cycles", txr_bad, 0);
        checkOutput("idle_port_nonzero_cycles", idle_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
